// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold
//   Round-robin arbiter with grant hold for multi-cycle transactions.
//   The grant is registered, one-hot, and stays on the winner until the
//   holder signals done_i. Priority rotates to the index after the last
//   holder. On release the next winner is loaded in the same edge, so
//   back-to-back grants have no idle bubble.
//
//   Optional macro ARB_TIMEOUT_EN: adds a hold counter that forces a
//   release after TIMEOUT_CYCLES BUSY cycles and pulses timeout_o.
//   Without it, timeout_o is tied low and TIMEOUT_CYCLES is unused.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   req_i        request vector, level-sensitive
//   done_i       current holder releases the resource this cycle
//   gnt_o        registered one-hot grant, zero when idle
//   gnt_id_o     binary index of the current grant (0 when idle)
//   gnt_valid_o  high while a grant is held
//   timeout_o    one-cycle pulse after a forced release
module rr_arbiter_hold #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int IDX_W         = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               done_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_id_o,
   output logic               gnt_valid_o,
   output logic               timeout_o
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   ptr, ptr_d;
   logic [NUM_REQ-1:0] gnt, gnt_d;
   logic [IDX_W-1:0]   gnt_id, gnt_id_d;
   logic               to_q, to_d;

   logic [IDX_W-1:0]   rel_ptr;   // index after the current holder, mod NUM_REQ
   logic [IDX_W-1:0]   start;     // first index searched this cycle
   logic [IDX_W-1:0]   win;
   logic               found;
   logic               expire;
   logic               release_c;
   logic               load;

   // First set request searching start, start+1, ... wrapping at NUM_REQ.
   // Iterating from the far end lets the nearest hit overwrite the others.
   function automatic logic [IDX_W:0] search(input logic [IDX_W-1:0] s,
                                              input logic [NUM_REQ-1:0] r);
      logic [IDX_W-1:0] w;
      logic             f;
      int               idx;
      w = '0;
      f = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(s) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (r[idx]) begin
            f = 1'b1;
            w = IDX_W'(idx);
         end
      end
      return {f, w};
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt, cnt_d;

   // cnt holds the number of completed BUSY cycles of the current grant,
   // so the TIMEOUT_CYCLES-th BUSY cycle is the one with cnt == T-1.
   assign expire = (state == BUSY) && !done_i &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_d  = (state == BUSY && !release_c) ? cnt + 1'b1 : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign expire         = 1'b0;
`endif

   assign rel_ptr   = (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
   assign release_c = (state == BUSY) && (done_i || expire);
   assign start     = (state == IDLE) ? ptr : rel_ptr;
   assign {found, win} = search(start, req_i);
   assign load      = found && ((state == IDLE) || release_c);

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         ptr    <= '0;
         gnt    <= '0;
         gnt_id <= '0;
         to_q   <= 1'b0;
      end else begin
         state  <= state_d;
         ptr    <= ptr_d;
         gnt    <= gnt_d;
         gnt_id <= gnt_id_d;
         to_q   <= to_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (found) state_d = BUSY;
         BUSY:    if (release_c) state_d = found ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next register values for pointer, grant and timeout pulse
   always_comb begin
      ptr_d    = ptr;
      gnt_d    = gnt;
      gnt_id_d = gnt_id;
      to_d     = expire;
      if (release_c) begin
         ptr_d    = rel_ptr;
         gnt_d    = '0;
         gnt_id_d = '0;
      end
      if (load) begin
         gnt_d    = NUM_REQ'(1) << win;
         gnt_id_d = win;
      end
   end

   assign gnt_o       = gnt;
   assign gnt_id_o    = gnt_id;
   assign gnt_valid_o = |gnt;
   assign timeout_o   = to_q;

endmodule

// File: doc/rr_arbiter_hold.md
Name: rr_arbiter_hold

Overview:
- Parametrised round-robin arbiter for NUM_REQ requesters, for use wherever a shared resource serves multi-cycle transactions.
- Grant is registered and one-hot, and stays on the winner until the winner signals done_i.
- Priority rotates so the requester after the last winner is searched first. Any continuously requesting channel is starvation-free.
- Back-to-back grants are supported with no idle bubble.

Parameters:
- NUM_REQ, 4, number of requesters. Legal range is >=2; need not be a power of two.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before a forced release. Used only with ARB_TIMEOUT_EN; legal range is >=1.
- IDX_W (localparam), $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_i  input  NUM_REQ  request vector, level-sensitive.
- done_i  input  1  current grant holder releases the resource this cycle.
- gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- gnt_id_o  output  IDX_W  binary index of the current grant.
- gnt_valid_o  output  1  high while a grant is held (equals |gnt_o).
- timeout_o  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (reset_n=0, asynchronous, including mid-BUSY):
  - state=IDLE, ptr=0.
  - gnt_o=0, gnt_id_o=0, gnt_valid_o=0, timeout_o=0.
  - Hold counter cleared.
- ptr is the highest-priority index. The winner search runs ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1 and takes the first set req_i bit. Index arithmetic wraps modulo NUM_REQ, not modulo 2^IDX_W.
- IDLE:
  - If |req_i at an edge: register the winner on gnt_o/gnt_id_o, set gnt_valid_o=1, go to BUSY.
  - Latency: request sampled at edge k, grant visible immediately after edge k.
  - No request: stay in IDLE with outputs at zero.
  - done_i is ignored in IDLE.
- BUSY:
  - The grant is held regardless of req_i. The holder dropping its request does not release it; only done_i (or a timeout) does.
  - On done_i=1: ptr <= (gnt_id_o+1) mod NUM_REQ. In the same edge, rerun the winner search from that new ptr on the current req_i:
    - If there is a winner: load the new grant and stay BUSY (back-to-back, no bubble).
    - If there is none: clear gnt_o, gnt_valid_o=0, go to IDLE.
  - The releasing requester can win again only if it is the sole requester.
- ptr changes only on release; it is never advanced in IDLE.
- Fairness: a requester holding req_i continuously receives a grant after at most NUM_REQ-1 other grants.
- gnt_o bits for indices not requesting at grant time are never set. gnt_o is never multi-hot.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - The hold counter increments every BUSY cycle and clears on any grant load.
  - When the counter reaches TIMEOUT_CYCLES with done_i=0, the arbiter performs the exact release sequence of done_i (ptr advance, immediate re-arbitration) and timeout_o=1 for that one cycle after the edge.
  - done_i asserted in the same cycle as expiry counts as a normal release: timeout_o stays 0.
- ARB_TIMEOUT_EN undefined:
  - No counter is instantiated, timeout_o is tied 0, and TIMEOUT_CYCLES is unused.
  - A grant is held indefinitely until done_i.

Test Plan:
- Reset then start:
  - Stimulus: reset_n=0, req_i=4'b1111 for 3 cycles.
  - Response: gnt_o=0 and gnt_valid_o=0 throughout. After reset_n=1, first edge gives gnt_o=0001, gnt_id_o=0.
- Rotation and back-to-back:
  - Stimulus: req_i=1111 held, done_i pulsed one cycle after each grant.
  - Response: gnt_o sequence 0001, 0010, 0100, 1000, 0001 with gnt_valid_o never dropping.
- Hold:
  - Stimulus: grant 0100 active; req_i drops to 0000; done_i=0 for 5 cycles.
  - Response: gnt_o stays 0100. On done_i, gnt_o=0000, gnt_valid_o=0, next grant search starts at index 3.
- Skip and wrap:
  - Stimulus: after a release of id 1 (ptr=2), req_i=1001.
  - Response: gnt_id_o=3. After done_i, gnt_id_o=0.
  - Repeat with NUM_REQ=3: release of id 2 with req_i=111 gives id 0, with no X on gnt_id_o.
- Asynchronous reset mid-BUSY:
  - Stimulus: grant 0010 held; pulse reset_n=0 between edges.
  - Response: gnt_o=0 immediately without waiting for an edge. After release with req_i=1111, grant returns to 0001 (ptr reset to 0).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: grant 0001, req_i=0011, done_i never asserted.
  - Response: after 4 BUSY cycles gnt_o=0010 and timeout_o=1 for exactly one cycle.
  - Repeat with done_i on the 4th cycle: gnt_o=0010 and timeout_o stays 0.
